// File: rtl/cdc_ctrl_pkg.sv
// Shared definitions for the req/ack CDC source controller.
// Holds the state encoding and the counter width helper.
package cdc_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_RELEASE = 2'd2,
        ST_ERROR   = 2'd3
    } state_t;

    // Bits needed to count 0..value-1, at least one.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/cdc_phase_timer.sv
// Per-phase cycle counter for the handshake controller.
// Flags expiry once the count reaches TIMEOUT-1; saturates there.
module cdc_phase_timer
    import cdc_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && (count != LAST)) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/cdc_req_ack_ctrl.sv
// Source-side 4-phase req/ack controller: takes one stream word,
// holds it on xfer_data and walks req/ack, with a phase timeout.
module cdc_req_ack_ctrl
    import cdc_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] xfer_data,
    output logic                  xfer_req,
    input  logic                  xfer_ack_sync,
    output logic                  xfer_done,
    output logic                  err,
    input  logic                  err_clr
);

    state_t state;
    state_t state_next;
    logic   accept;
    logic   timer_clr;
    logic   timer_en;
    logic   expired;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Exit conditions are tested before expiry so a late ack still wins.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (xfer_ack_sync) begin
                    state_next = ST_RELEASE;
                end else if (expired) begin
                    state_next = ST_ERROR;
                end
            end
            ST_RELEASE: begin
                if (!xfer_ack_sync) begin
                    state_next = ST_IDLE;
                end else if (expired) begin
                    state_next = ST_ERROR;
                end
            end
            ST_ERROR: begin
                if (err_clr && !xfer_ack_sync) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        s_axis_tready = (state == ST_IDLE) && !xfer_ack_sync;
        accept        = s_axis_tvalid && s_axis_tready;
        timer_en      = (state == ST_REQ) || (state == ST_RELEASE);
        timer_clr     = (state_next != state);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_req  <= 1'b0;
            xfer_data <= '0;
            xfer_done <= 1'b0;
            err       <= 1'b0;
        end else begin
            xfer_req  <= (state_next == ST_REQ);
            xfer_done <= (state == ST_RELEASE) && (state_next == ST_IDLE);
            err       <= (state_next == ST_ERROR);
            if (accept) begin
                xfer_data <= s_axis_tdata;
            end
        end
    end

    cdc_phase_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (timer_clr),
        .en     (timer_en),
        .expired(expired)
    );

endmodule

// File: tb/tb_cdc_req_ack_ctrl.sv
// Bench for cdc_req_ack_ctrl: directed handshake cases plus random
// traffic against a transaction-level destination model.
module tb_cdc_req_ack_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic [7:0] xdata;
    logic       req;
    logic       ack;
    logic       done;
    logic       err;
    logic       err_clr;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] src_q[$];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    cdc_req_ack_ctrl #(
        .DATA_WIDTH(8),
        .TIMEOUT   (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis_tdata (tdata),
        .s_axis_tvalid(tvalid),
        .s_axis_tready(tready),
        .xfer_data    (xdata),
        .xfer_req     (req),
        .xfer_ack_sync(ack),
        .xfer_done    (done),
        .err          (err),
        .err_clr      (err_clr)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic finish_hs(input string tag);
        ack = 1'b1;
        step();
        check({tag, "_req_fall"}, req, 0);
        ack = 1'b0;
        step();
        check({tag, "_done"}, done, 1);
        step();
        check({tag, "_done_one"}, done, 0);
    endtask

    // Destination echoes req after dly samples; source offers src_q.
    // A word is outstanding from its accept edge until its done pulse.
    task automatic traffic(input string tag, input int cycles,
                           input int dmin, input int dmax,
                           input int pct);
        logic [7:0] hist;
        logic [7:0] held;
        logic       prev_req;
        int         dly;
        int         outst;
        int         ndone;
        int         nwords;
        bit         pend;
        hist     = '0;
        held     = '0;
        prev_req = req;
        dly      = dmin;
        outst    = 0;
        ndone    = 0;
        pend     = 0;
        nwords   = src_q.size();
        tvalid   = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            if (pend) begin
                outst++;
                pend   = 0;
                tvalid = 1'b0;
            end
            if (done) begin
                ndone++;
                outst--;
            end
            if (err) begin
                check({tag, "_err"}, err, 0);
            end
            if (req && !prev_req) begin
                if (exp_q.size() == 0) begin
                    check({tag, "_spurious_req"}, 1, 0);
                end else begin
                    held = exp_q.pop_front();
                    check({tag, "_word"}, xdata, held);
                end
            end else if (req && (xdata !== held)) begin
                check({tag, "_hold"}, xdata, held);
            end
            prev_req = req;
            hist = {hist[6:0], req};
            if (outst == 0 && hist == 0) begin
                dly = $urandom_range(dmax, dmin);
            end
            ack = hist[dly];
            if (!tvalid && src_q.size() > 0 &&
                $urandom_range(99, 0) < pct) begin
                tvalid = 1'b1;
                tdata  = src_q[0];
            end
            #1;
            check({tag, "_tready"}, tready, (outst == 0) && !ack);
            if (tvalid && tready) begin
                pend = 1;
                exp_q.push_back(tdata);
                void'(src_q.pop_front());
            end
            if (src_q.size() == 0 && outst == 0 && !pend && !req &&
                !ack && c > 0) begin
                break;
            end
            @(posedge clk);
            #1;
        end
        tvalid = 1'b0;
        ack    = 1'b0;
        check({tag, "_drain"}, src_q.size() + outst + int'(pend), 0);
        check({tag, "_done_cnt"}, ndone, nwords);
        src_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        tvalid  = 1'b0;
        tdata   = '0;
        ack     = 1'b0;
        err_clr = 1'b0;
        step();
        step();
        check("rst_req", req, 0);
        check("rst_data", xdata, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_tready", tready, 1);
        rst = 1'b0;
        step();

        // Single word, ack raised five cycles after req.
        tvalid = 1'b1;
        tdata  = 8'hA5;
        step();
        check("t1_req", req, 1);
        check("t1_data", xdata, 8'hA5);
        check("t1_tready_busy", tready, 0);
        tvalid = 1'b0;
        tdata  = 8'h00;
        repeat (4) step();
        check("t1_req_held", req, 1);
        ack = 1'b1;
        step();
        check("t1_req_fall", req, 0);
        check("t1_data_rel", xdata, 8'hA5);
        ack = 1'b0;
        #1;
        check("t1_tready_rel", tready, 0);
        step();
        check("t1_done", done, 1);
        check("t1_tready_idle", tready, 1);
        step();
        check("t1_done_one", done, 0);

        // Back-to-back words with ack echoing req after 4 cycles.
        src_q = '{8'h01, 8'h02, 8'h03};
        traffic("t2", 100, 4, 4, 100);

        // REQ phase timeout, then recovery gated by ack.
        tvalid = 1'b1;
        tdata  = 8'h77;
        step();
        tvalid = 1'b0;
        repeat (7) step();
        check("t3_pre_err", err, 0);
        check("t3_pre_req", req, 1);
        step();
        check("t3_err", err, 1);
        check("t3_req", req, 0);
        check("t3_tready", tready, 0);
        ack     = 1'b1;
        err_clr = 1'b1;
        step();
        check("t3_clr_blocked", err, 1);
        ack = 1'b0;
        step();
        err_clr = 1'b0;
        check("t3_recover", err, 0);
        check("t3_tready_idle", tready, 1);

        // Ack arrives on the last allowed REQ cycle; then RELEASE stalls.
        tvalid = 1'b1;
        tdata  = 8'h44;
        step();
        tvalid = 1'b0;
        repeat (7) step();
        ack = 1'b1;
        step();
        check("t4_exit_req", req, 0);
        check("t4_exit_err", err, 0);
        repeat (7) step();
        check("t4_rel_pre_err", err, 0);
        step();
        check("t4_rel_err", err, 1);
        ack     = 1'b0;
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("t4_recover", err, 0);
        check("t4_no_done", done, 0);

        // Stale ack in IDLE blocks acceptance until it drops.
        ack    = 1'b1;
        tvalid = 1'b1;
        tdata  = 8'h5A;
        #1;
        check("t5_tready_blk", tready, 0);
        repeat (3) step();
        check("t5_no_req", req, 0);
        ack = 1'b0;
        #1;
        check("t5_tready_now", tready, 1);
        step();
        tvalid = 1'b0;
        check("t5_req", req, 1);
        check("t5_data", xdata, 8'h5A);
        finish_hs("t5");

        // Reset during REQ, then a normal transfer.
        tvalid = 1'b1;
        tdata  = 8'h3C;
        step();
        check("t6_req", req, 1);
        rst = 1'b1;
        step();
        check("t6_rst_req", req, 0);
        check("t6_rst_data", xdata, 0);
        check("t6_rst_err", err, 0);
        rst = 1'b0;
        #1;
        check("t6_tready", tready, 1);
        step();
        tvalid = 1'b0;
        check("t6_req2", req, 1);
        check("t6_data2", xdata, 8'h3C);
        finish_hs("t6");

        // Random traffic with varying destination delay.
        for (int i = 0; i < 40; i++) begin
            src_q.push_back(8'($urandom));
        end
        traffic("rnd", 2000, 0, 4, 60);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
